// File: rtl/urv_ahb_pkg.sv
// Shared AHB-Lite encodings, common to the data and instruction-fetch masters.
package urv_ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransNonseq = 2'b10
  } htrans_e;

  typedef enum logic [2:0] {
    HsizeByte = 3'b000,
    HsizeHalf = 3'b001,
    HsizeWord = 3'b010
  } hsize_e;

  localparam logic [2:0] HburstSingle = 3'b000;

endpackage

// File: rtl/urv_dm_lane_decode.sv
// Byte-lane enables to AHB transfer size and address offset; flags patterns that
// cannot be expressed as a single naturally aligned transfer.
module urv_dm_lane_decode
  import urv_ahb_pkg::*;
(
  input  logic [3:0] lanes,
  output hsize_e     size,
  output logic [1:0] offset,
  output logic       legal
);

  always_comb begin
    size   = HsizeByte;
    offset = 2'b00;
    legal  = 1'b1;
    case (lanes)
      4'b1111: size = HsizeWord;
      4'b0011: size = HsizeHalf;
      4'b1100: begin
        size   = HsizeHalf;
        offset = 2'b10;
      end
      4'b0001: offset = 2'b00;
      4'b0010: offset = 2'b01;
      4'b0100: offset = 2'b10;
      4'b1000: offset = 2'b11;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/urv_dm_ahb_bridge.sv
// Single-outstanding bridge from the CPU data port to an AHB-Lite master.
// Illegal lane patterns complete locally with an error and never reach the bus.
module urv_dm_ahb_bridge
  import urv_ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_ready_o,
  output logic        bus_err_o,
  output logic [31:0] HADDR_O,
  output logic [1:0]  HTRANS_O,
  output logic [2:0]  HSIZE_O,
  output logic [2:0]  HBURST_O,
  output logic [3:0]  HPROT_O,
  output logic        HMASTLOCK_O,
  output logic        HWRITE_O,
  output logic [31:0] HWDATA_O,
  input  logic [31:0] HRDATA_I,
  input  logic        HREADY_I,
  input  logic        HRESP_I
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  hsize_e      size_q;
  logic        write_q, legal_q;
  logic        load_done_q, store_done_q, err_q;

  hsize_e      dec_size;
  logic [1:0]  dec_offset;
  logic        dec_legal;
  logic        accept, finish, bus_ok;

  urv_dm_lane_decode u_lane_decode (
    .lanes  (dm_data_select_i),
    .size   (dec_size),
    .offset (dec_offset),
    .legal  (dec_legal)
  );

  assign accept = (state_q == StIdle) && (dm_load_i || dm_store_i);
  // An illegal request spends its single ADDR cycle idle on the bus, then completes.
  assign finish = ((state_q == StAddr) && !legal_q) || ((state_q == StData) && HREADY_I);
  assign bus_ok = (state_q == StData) && HREADY_I && !HRESP_I;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (dm_load_i || dm_store_i) state_d = StAddr;
      StAddr: begin
        if (!legal_q) begin
          state_d = StIdle;
        end else if (HREADY_I) begin
          state_d = StData;
        end
      end
      StData: if (HREADY_I) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dm_ready_o = (state_q == StIdle);
    HTRANS_O   = HtransIdle;
    if ((state_q == StAddr) && legal_q) begin
      HTRANS_O = HtransNonseq;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      size_q       <= HsizeByte;
      write_q      <= 1'b0;
      legal_q      <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= (dm_addr_i & ~32'h3) | {30'b0, dec_offset};
        wdata_q <= dm_data_s_i;
        size_q  <= dec_size;
        write_q <= dm_store_i;
        legal_q <= dec_legal;
      end
      if (bus_ok && !write_q) begin
        rdata_q <= HRDATA_I;
      end
      load_done_q  <= finish && !write_q;
      store_done_q <= finish && write_q;
      err_q        <= finish && !bus_ok;
    end
  end

  assign dm_data_l_o     = rdata_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign bus_err_o       = err_q;

  assign HADDR_O     = addr_q;
  assign HSIZE_O     = size_q;
  assign HWRITE_O    = write_q;
  assign HWDATA_O    = wdata_q;
  assign HBURST_O    = HburstSingle;
  assign HPROT_O     = HPROT_VAL;
  assign HMASTLOCK_O = 1'b0;

endmodule

// File: tb/tb_urv_dm_ahb_bridge.sv
// Scoreboard bench: driver pushes expected bus and completion records, the slave
// model and completion monitor pop and compare them independently.
module tb_urv_dm_ahb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dm_addr_i = '0, dm_data_s_i = '0;
  logic [3:0]  dm_data_select_i = '0;
  logic        dm_store_i = 1'b0, dm_load_i = 1'b0;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o, dm_store_done_o, dm_ready_o, bus_err_o;
  logic [31:0] HADDR_O, HWDATA_O;
  logic [1:0]  HTRANS_O;
  logic [2:0]  HSIZE_O, HBURST_O;
  logic [3:0]  HPROT_O;
  logic        HMASTLOCK_O, HWRITE_O;
  logic [31:0] HRDATA_I = '0;
  logic        HREADY_I = 1'b1, HRESP_I = 1'b0;

  urv_dm_ahb_bridge #(.HPROT_VAL(4'b0001)) dut (
    .clk_i(clk), .rst_i(rst),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
    .dm_store_done_o(dm_store_done_o), .dm_ready_o(dm_ready_o), .bus_err_o(bus_err_o),
    .HADDR_O(HADDR_O), .HTRANS_O(HTRANS_O), .HSIZE_O(HSIZE_O), .HBURST_O(HBURST_O),
    .HPROT_O(HPROT_O), .HMASTLOCK_O(HMASTLOCK_O), .HWRITE_O(HWRITE_O), .HWDATA_O(HWDATA_O),
    .HRDATA_I(HRDATA_I), .HREADY_I(HREADY_I), .HRESP_I(HRESP_I)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [2:0] size; logic write; logic [31:0] wdata;} bus_t;
  typedef struct {logic store; logic err; logic [31:0] data_l;} done_t;

  bus_t        bus_q[$];
  done_t       done_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = '0;
  int          cfg_aw = 0, cfg_dw = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lane rules: full word, aligned halves, or any single byte.
  function automatic void lane_model(input logic [3:0] lanes, output logic legal,
                                     output logic [2:0] size, output logic [1:0] off);
    legal = 1'b1; size = 3'd0; off = 2'd0;
    if (lanes == 4'hF) size = 3'd2;
    else if (lanes == 4'h3) size = 3'd1;
    else if (lanes == 4'hC) begin size = 3'd1; off = 2'd2; end
    else if ($countones(lanes) == 1) begin
      for (int i = 0; i < 4; i++) if (lanes[i]) off = 2'(i);
    end else legal = 1'b0;
  endfunction

  // Completion monitor.
  always @(negedge clk) begin
    done_t e;
    if (!rst && (dm_load_done_o || dm_store_done_o || bus_err_o)) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got ld=%b st=%b err=%b, required none",
                 dm_load_done_o, dm_store_done_o, bus_err_o);
      end else begin
        e = done_q.pop_front();
        chk("done_type", {30'b0, dm_store_done_o, dm_load_done_o}, e.store ? 32'd2 : 32'd1);
        chk("bus_err", {31'b0, bus_err_o}, {31'b0, e.err});
        chk("data_l", dm_data_l_o, e.data_l);
      end
    end
  end

  task automatic serve();
    bus_t b;
    if (bus_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_nonseq: got HADDR=%h, required no transfer", HADDR_O);
      return;
    end
    b = bus_q.pop_front();
    chk("haddr", HADDR_O, b.addr);
    chk("hsize", {29'b0, HSIZE_O}, {29'b0, b.size});
    chk("hwrite", {31'b0, HWRITE_O}, {31'b0, b.write});
    chk("hburst_lock_prot", {24'b0, HBURST_O, HMASTLOCK_O, HPROT_O}, 32'h1);
    for (int i = 0; i < cfg_aw; i++) begin
      HREADY_I = 1'b0;
      @(negedge clk);
      if (rst) begin HREADY_I = 1'b1; return; end
      chk("addr_hold", {HTRANS_O, HADDR_O[29:0]}, {2'b10, b.addr[29:0]});
    end
    HREADY_I = 1'b1;
    @(negedge clk);
    if (rst) return;
    chk("htrans_data", {30'b0, HTRANS_O}, 32'd0);
    if (b.write) chk("hwdata", HWDATA_O, b.wdata);
    if (cfg_err) begin
      HREADY_I = 1'b0; HRESP_I = 1'b1; HRDATA_I = $urandom;
      @(negedge clk);
      if (rst) begin HREADY_I = 1'b1; HRESP_I = 1'b0; return; end
      HREADY_I = 1'b1;
      @(negedge clk);
      HRESP_I = 1'b0;
    end else begin
      for (int i = 0; i < cfg_dw; i++) begin
        HREADY_I = 1'b0; HRDATA_I = $urandom;
        @(negedge clk);
        if (rst) begin HREADY_I = 1'b1; return; end
      end
      HREADY_I = 1'b1; HRDATA_I = cfg_rdata;
      @(negedge clk);
      HRDATA_I = $urandom;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && HTRANS_O == 2'b10) serve();
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] lanes, input int aw,
                       input int dw, input logic err, input logic [31:0] rdata);
    logic legal; logic [2:0] size; logic [1:0] off;
    bus_t b; done_t d; int expk; int k;
    lane_model(lanes, legal, size, off);
    if (legal) begin
      b.addr = {addr[31:2], off}; b.size = size; b.write = st; b.wdata = wdata;
      bus_q.push_back(b);
    end
    if (legal && !err && !st) model_rdata = rdata;
    d.store = st; d.err = !legal || err; d.data_l = model_rdata;
    done_q.push_back(d);
    expk = !legal ? 2 : 3 + aw + (err ? 1 : dw);
    cfg_aw = aw; cfg_dw = err ? 0 : dw; cfg_err = err; cfg_rdata = rdata;
    chk("ready_idle", {31'b0, dm_ready_o}, 32'd1);
    dm_addr_i = addr; dm_data_s_i = wdata; dm_data_select_i = lanes;
    dm_load_i = ld; dm_store_i = st;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      // Scramble request fields while busy; they must already be registered.
      dm_addr_i = $urandom; dm_data_s_i = $urandom; dm_data_select_i = 4'($urandom);
      if (!(dm_load_done_o || dm_store_done_o)) chk("ready_busy", {31'b0, dm_ready_o}, 32'd0);
    end while (!(dm_load_done_o || dm_store_done_o) && k < 40);
    chk("latency", k, expk);
    dm_load_i = 1'b0; dm_store_i = 1'b0;
  endtask

  initial begin
    logic [3:0] tbl [7];
    bus_t b;
    logic ld, st;
    logic [3:0] lanes;
    tbl = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    repeat (2) @(negedge clk);
    chk("rst_htrans", {30'b0, HTRANS_O}, 32'd0);
    chk("rst_haddr", HADDR_O, 32'd0);
    chk("rst_hwdata", HWDATA_O, 32'd0);
    chk("rst_hsize_hwrite", {28'b0, HSIZE_O, HWRITE_O}, 32'd0);
    chk("rst_data_l", dm_data_l_o, 32'd0);
    chk("rst_pulses", {29'b0, dm_load_done_o, dm_store_done_o, bus_err_o}, 32'd0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", {29'b0, HTRANS_O, dm_ready_o}, 32'd1);
    end

    issue(1, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 0, 32'hDEAD_BEEF);
    issue(0, 1, 32'h0000_0200, 32'h00AB_0000, 4'b0100, 0, 0, 0, 32'h0);
    issue(1, 0, 32'h0000_0300, 32'h0, 4'b1100, 0, 2, 0, 32'h1234_5678);
    issue(0, 1, 32'h0000_0400, 32'h55, 4'b0101, 0, 0, 0, 32'h0);
    issue(1, 0, 32'h0000_0500, 32'h0, 4'hF, 0, 0, 1, 32'hBAD0_BAD0);
    issue(1, 0, 32'h0000_0504, 32'h0, 4'b0011, 1, 0, 0, 32'hCAFE_F00D);
    issue(1, 1, 32'h0000_0508, 32'h7777_7777, 4'hF, 0, 1, 0, 32'h0);

    for (int n = 0; n < 150; n++) begin
      ld = 1'($urandom); st = 1'($urandom);
      if (!ld && !st) ld = 1'b1;
      lanes = ($urandom % 8 < 6) ? tbl[$urandom % 7] : 4'($urandom);
      issue(ld, st, $urandom, $urandom, lanes, $urandom % 3, $urandom % 3,
            ($urandom % 8) == 0, $urandom);
      repeat ($urandom % 3) @(negedge clk);
    end

    // Reset in the data phase of a store: bus idles at once, no completion follows.
    cfg_aw = 0; cfg_dw = 6; cfg_err = 1'b0;
    b.addr = 32'h0000_0600; b.size = 3'd2; b.write = 1'b1; b.wdata = 32'h0F0F_0F0F;
    bus_q.push_back(b);
    dm_addr_i = 32'h600; dm_data_s_i = 32'h0F0F_0F0F; dm_data_select_i = 4'hF;
    dm_store_i = 1'b1;
    repeat (2) @(negedge clk);
    dm_store_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_htrans", {30'b0, HTRANS_O}, 32'd0);
    chk("mid_rst_haddr_hwdata", HADDR_O | HWDATA_O, 32'd0);
    chk("mid_rst_ready", {31'b0, dm_ready_o}, 32'd1);
    chk("mid_rst_data_l", dm_data_l_o, 32'd0);
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_idle", {29'b0, HTRANS_O, dm_ready_o}, 32'd1);
    end
    issue(1, 0, 32'h0000_0700, 32'h0, 4'b1000, 0, 0, 0, 32'hA5A5_5A5A);

    repeat (3) @(negedge clk);
    chk("done_q_drained", done_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/urv_dm_ahb_bridge.md
URV_DM_AHB_BRIDGE -- requirements
Module: urv_dm_ahb_bridge

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0001, giving the constant driven on HPROT_O (data access).
REQ-002 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port dm_addr_i, input, 32, CPU data address.
REQ-005 SHALL have port dm_data_s_i, input, 32, store data, lane-aligned.
REQ-006 SHALL have port dm_data_select_i, input, 4, byte-lane enables.
REQ-007 SHALL have ports dm_store_i and dm_load_i, input, 1 each, request strobes.
REQ-008 SHALL have ports dm_data_l_o (32), dm_load_done_o (1), dm_store_done_o (1), dm_ready_o (1) and bus_err_o (1), all outputs.
REQ-009 SHALL have AHB-Lite master outputs HADDR_O (32), HTRANS_O (2), HSIZE_O (3), HBURST_O (3), HPROT_O (4), HMASTLOCK_O (1), HWRITE_O (1) and HWDATA_O (32).
REQ-010 SHALL have AHB-Lite inputs HRDATA_I (32), HREADY_I (1) and HRESP_I (1).

Function
REQ-011 SHALL use states IDLE, ADDR and DATA; dm_ready_o = 1 only in IDLE.
REQ-012 SHALL accept a request in IDLE when dm_load_i or dm_store_i is 1; if both are 1, the store SHALL win.
REQ-013 SHALL register the address, data, lanes and direction on acceptance and enter ADDR on the next edge.
REQ-014 SHALL map lanes to transfer size and address as follows:
- 1111 -> HSIZE 010, HADDR[1:0]=00.
- 0011 -> HSIZE 001, offset 00.
- 1100 -> HSIZE 001, offset 10.
- single bit k -> HSIZE 000, offset k.
REQ-015 SHALL treat any other lane pattern as illegal: no bus transfer, a done pulse for the request type one cycle after acceptance, and bus_err_o pulsed in the same cycle.
REQ-016 SHALL, in ADDR, drive HTRANS_O=NONSEQ(10), HBURST_O=000, HMASTLOCK_O=0 and the registered HADDR/HSIZE/HWRITE; advance to DATA on HREADY_I=1, otherwise hold every address-phase output.
REQ-017 SHALL drive HTRANS_O=IDLE(00) in every state other than ADDR.
REQ-018 SHALL drive HWDATA_O with the registered store data throughout DATA.
REQ-019 SHALL, in DATA with HREADY_I=1 and HRESP_I=0, complete the transfer:
- capture HRDATA_I into dm_data_l_o for a load;
- pulse dm_load_done_o or dm_store_done_o for exactly 1 cycle on the next edge;
- return to IDLE.
REQ-020 SHALL, on HRESP_I=1 in DATA, wait for the second error cycle (HREADY_I=1), then pulse done together with bus_err_o and return to IDLE with no retry.
REQ-021 SHALL hold dm_data_l_o between loads; stores SHALL NOT alter it.
REQ-022 SHALL give a minimum latency, zero-wait slave, of acceptance at edge N, NONSEQ during N..N+1, data phase N+1..N+2, done high N+2..N+3; each slave wait cycle SHALL add 1.
REQ-023 SHALL ignore requests presented while dm_ready_o=0; the CPU holds strobes until ready.

Reset
REQ-024 SHALL, on rst_i=1 asynchronously, force the following (any state, including mid-transfer):
- state IDLE;
- HTRANS_O=00, HWRITE_O=0, HADDR_O=0, HSIZE_O=0, HWDATA_O=0;
- dm_data_l_o=0, all done/err pulses 0, dm_ready_o=1 after release.
REQ-025 SHALL NOT issue any transfer on the first edge after rst_i deasserts unless a request is present.

Structure
REQ-026 SHALL take HTRANS encodings (IDLE, NONSEQ) and HSIZE encodings (BYTE, HALF, WORD) from shared package urv_ahb_pkg, for reuse by the instruction-fetch master.
REQ-027 SHALL place the lane-to-size/offset decode in sub-module urv_dm_lane_decode (combinational, with a legal flag); everything else SHALL be flat.

Verification
REQ-028 SHALL cover a word load at 0x0000_0100 with zero-wait slave returning 0xDEADBEEF -> HADDR 0x100, HSIZE 010, done 3 cycles after acceptance, dm_data_l_o=0xDEADBEEF.
REQ-029 SHALL cover a byte store, lanes 0100, address 0x0000_0200, data 0x00AB0000 -> HADDR 0x202, HSIZE 000, HWRITE 1, HWDATA 0x00AB0000, one dm_store_done_o pulse.
REQ-030 SHALL cover a halfword load, lanes 1100, with slave inserting 2 wait states in the data phase -> done at cycle 5, dm_ready_o low throughout.
REQ-031 SHALL cover lanes 0101 on a store -> no NONSEQ issued, dm_store_done_o and bus_err_o pulse together 1 cycle after acceptance.
REQ-032 SHALL cover a two-cycle ERROR response on a load -> done plus bus_err_o pulse, dm_data_l_o unchanged, next request accepted normally.
REQ-033 SHALL cover rst_i asserted during DATA of a store -> HTRANS 00 immediately, no done pulse, IDLE after release.
